// File: rtl/matbi_watch_time_cnt.sv
// -----------------------------------------------------------------------------
// matbi_watch_time_cnt
//
// Wall-clock time counter (hour:min:sec) driven by a one-second tick, with a
// two-state run control and a time-load port that is only open while stopped.
//
// State table
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | stopped; ticks discarded; time may be loaded
//   S_RUN  | counting one second per accepted tick; loads refused
//
// Parameters
//   P_HOUR_MAX     hour modulus (2..32), e.g. 24 for a 24-hour clock
//
// Ports
//   clk            single clock, rising edge
//   reset          asynchronous active-high reset
//   i_one_sec_tick one-cycle pulse per elapsed second
//   i_start        request IDLE -> RUN
//   i_stop         request RUN -> IDLE (wins over i_start)
//   i_set_valid    time-load request, held by upstream until accepted
//   i_set_hour     load value, hours
//   i_set_min      load value, minutes
//   i_set_sec      load value, seconds
//   o_set_ready    high while a load can be accepted (IDLE)
//   o_set_err      one-cycle pulse when an accepted load was out of range
//   o_hour         current hours   (registered)
//   o_min          current minutes (registered)
//   o_sec          current seconds (registered)
//   o_running      high while in RUN
//   o_day_tick     one-cycle pulse when the hour count wraps to zero
// -----------------------------------------------------------------------------
module matbi_watch_time_cnt #(
    parameter int P_HOUR_MAX = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_one_sec_tick,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_set_valid,
    input  logic [4:0] i_set_hour,
    input  logic [5:0] i_set_min,
    input  logic [5:0] i_set_sec,
    output logic       o_set_ready,
    output logic       o_set_err,
    output logic [4:0] o_hour,
    output logic [5:0] o_min,
    output logic [5:0] o_sec,
    output logic       o_running,
    output logic       o_day_tick
);

    localparam logic [5:0] SEC_LAST  = 6'd59;
    localparam logic [5:0] MIN_LAST  = 6'd59;
    localparam logic [5:0] SEC_LIM   = 6'd60;
    localparam logic [5:0] MIN_LIM   = 6'd60;
    localparam logic [4:0] HOUR_LAST = 5'(P_HOUR_MAX - 1);
    // One bit wider than the hour field so P_HOUR_MAX = 32 accepts every code.
    localparam logic [5:0] HOUR_LIM  = 6'(P_HOUR_MAX);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [4:0] hour_q;
    logic [5:0] min_q;
    logic [5:0] sec_q;
    logic [4:0] hour_nxt;
    logic [5:0] min_nxt;
    logic [5:0] sec_nxt;

    logic       set_err_q;
    logic       day_tick_q;
    logic       set_err_nxt;
    logic       day_tick_nxt;

    logic       cnt_en;
    logic       load_acc;
    logic       load_in_range;
    logic       load_ok;
    logic       sec_wrap;
    logic       min_wrap;
    logic       hour_wrap;

    // ------------------------------------------------------------------
    // Run control
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (i_start && !i_stop) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // A lone i_start while running is intentionally ignored.
                if (i_stop) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Qualifiers
    // ------------------------------------------------------------------
    // Counting is qualified by the current state only, so a tick arriving
    // with i_stop is still counted on the edge that drops back to IDLE.
    assign cnt_en        = (state == S_RUN) && i_one_sec_tick;
    assign load_acc      = (state == S_IDLE) && i_set_valid;
    assign load_in_range = (i_set_sec < SEC_LIM) &&
                           (i_set_min < MIN_LIM) &&
                           ({1'b0, i_set_hour} < HOUR_LIM);
    assign load_ok       = load_acc && load_in_range;

    assign sec_wrap  = cnt_en && (sec_q == SEC_LAST);
    assign min_wrap  = sec_wrap && (min_q == MIN_LAST);
    assign hour_wrap = min_wrap && (hour_q == HOUR_LAST);

    // ------------------------------------------------------------------
    // Time next-value: the whole cascade is resolved in one cycle so no
    // partially wrapped value is ever registered.
    // ------------------------------------------------------------------
    always_comb begin
        hour_nxt = hour_q;
        min_nxt  = min_q;
        sec_nxt  = sec_q;

        if (load_ok) begin
            hour_nxt = i_set_hour;
            min_nxt  = i_set_min;
            sec_nxt  = i_set_sec;
        end else if (cnt_en) begin
            if (sec_wrap) begin
                sec_nxt = '0;
            end else begin
                sec_nxt = sec_q + 6'd1;
            end

            if (min_wrap) begin
                min_nxt = '0;
            end else if (sec_wrap) begin
                min_nxt = min_q + 6'd1;
            end

            if (hour_wrap) begin
                hour_nxt = '0;
            end else if (min_wrap) begin
                hour_nxt = hour_q + 5'd1;
            end
        end
    end

    always_comb begin
        set_err_nxt  = 1'b0;
        day_tick_nxt = 1'b0;
        if (load_acc && !load_in_range) begin
            set_err_nxt = 1'b1;
        end
        if (hour_wrap) begin
            day_tick_nxt = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Time and pulse registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hour_q     <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            set_err_q  <= 1'b0;
            day_tick_q <= 1'b0;
        end else begin
            hour_q     <= hour_nxt;
            min_q      <= min_nxt;
            sec_q      <= sec_nxt;
            set_err_q  <= set_err_nxt;
            day_tick_q <= day_tick_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_hour      = hour_q;
    assign o_min       = min_q;
    assign o_sec       = sec_q;
    assign o_set_err   = set_err_q;
    assign o_day_tick  = day_tick_q;
    // Both are straight decodes of the single state flop.
    assign o_running   = (state == S_RUN);
    assign o_set_ready = (state == S_IDLE);

endmodule

// File: tb/tb_matbi_watch_time_cnt.sv
// -----------------------------------------------------------------------------
// Testbench for matbi_watch_time_cnt.
// The reference model keeps the time as seconds-of-day and the run flag as a
// bit; every driven cycle pushes the expected post-edge outputs into a queue
// that a separate monitor pops and compares one step after each rising edge.
// -----------------------------------------------------------------------------
module tb_matbi_watch_time_cnt;

    localparam int P = 24;
    localparam int DAY_SECS = P * 3600;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_one_sec_tick;
    logic       i_start;
    logic       i_stop;
    logic       i_set_valid;
    logic [4:0] i_set_hour;
    logic [5:0] i_set_min;
    logic [5:0] i_set_sec;
    logic       o_set_ready;
    logic       o_set_err;
    logic [4:0] o_hour;
    logic [5:0] o_min;
    logic [5:0] o_sec;
    logic       o_running;
    logic       o_day_tick;

    matbi_watch_time_cnt #(.P_HOUR_MAX(P)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_one_sec_tick (i_one_sec_tick),
        .i_start        (i_start),
        .i_stop         (i_stop),
        .i_set_valid    (i_set_valid),
        .i_set_hour     (i_set_hour),
        .i_set_min      (i_set_min),
        .i_set_sec      (i_set_sec),
        .o_set_ready    (o_set_ready),
        .o_set_err      (o_set_err),
        .o_hour         (o_hour),
        .o_min          (o_min),
        .o_sec          (o_sec),
        .o_running      (o_running),
        .o_day_tick     (o_day_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hour;
        int min;
        int sec;
        bit running;
        bit ready;
        bit err;
        bit day;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int m_t   = 0;   // seconds since midnight
    bit m_run = 1'b0;

    task automatic compare(input string name, input exp_t e);
        checks++;
        if (int'(o_hour) != e.hour || int'(o_min) != e.min || int'(o_sec) != e.sec ||
            o_running != e.running || o_set_ready != e.ready ||
            o_set_err != e.err || o_day_tick != e.day) begin
            errors++;
            $display("FAIL %s t=%0t got %0d:%0d:%0d run=%0b rdy=%0b err=%0b day=%0b want %0d:%0d:%0d run=%0b rdy=%0b err=%0b day=%0b",
                     name, $time, o_hour, o_min, o_sec, o_running, o_set_ready, o_set_err, o_day_tick,
                     e.hour, e.min, e.sec, e.running, e.ready, e.err, e.day);
        end
    endtask

    // Monitor: one step after each rising edge, check any pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                compare("cycle", e);
            end
        end
    end

    // Drive one cycle of inputs and predict the result of the next edge.
    task automatic apply(input bit start, input bit stop, input bit tick,
                         input bit valid, input int h, input int m, input int s);
        exp_t e;
        @(negedge clk);
        i_start        = start;
        i_stop         = stop;
        i_one_sec_tick = tick;
        i_set_valid    = valid;
        i_set_hour     = 5'(h);
        i_set_min      = 6'(m);
        i_set_sec      = 6'(s);

        e.err = 1'b0;
        e.day = 1'b0;
        if (!m_run && valid) begin
            if (h < P && m < 60 && s < 60) m_t = h * 3600 + m * 60 + s;
            else e.err = 1'b1;
        end
        if (m_run && tick) begin
            m_t = (m_t + 1) % DAY_SECS;
            if (m_t == 0) e.day = 1'b1;
        end
        if (!m_run) m_run = start && !stop;
        else        m_run = !stop;

        e.hour    = m_t / 3600;
        e.min     = (m_t / 60) % 60;
        e.sec     = m_t % 60;
        e.running = m_run;
        e.ready   = !m_run;
        q.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle_cycle();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    // Compare outputs against fixed values just after the edge that apply() ended on.
    task automatic chk_now(input string name, input int h, input int m, input int s,
                           input bit run, input bit err, input bit day);
        exp_t e;
        #2;
        e.hour = h; e.min = m; e.sec = s;
        e.running = run; e.ready = !run; e.err = err; e.day = day;
        compare(name, e);
    endtask

    task automatic zero_inputs();
        i_start = 1'b0; i_stop = 1'b0; i_one_sec_tick = 1'b0; i_set_valid = 1'b0;
        i_set_hour = '0; i_set_min = '0; i_set_sec = '0;
    endtask

    // Reset asserted between clock edges; outputs must clear without an edge.
    task automatic async_reset(input string name);
        #3;
        zero_inputs();
        reset = 1'b1;
        #1;
        chk_now(name, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        m_t   = 0;
        m_run = 1'b0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bit st, sp, tk, vl;
        int h, m, s;

        zero_inputs();
        reset = 1'b1;
        #1;
        chk_now("reset_hold", 0, 0, 0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle_cycle();
        chk_now("post_reset_idle", 0, 0, 0, 1'b0, 1'b0, 1'b0);

        // Start then 61 ticks
        apply(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        repeat (61) apply(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
        chk_now("count_61", 0, 1, 1, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        chk_now("stop", 0, 1, 1, 1'b0, 1'b0, 1'b0);

        // Rejected loads
        apply(1'b0, 1'b0, 1'b0, 1'b1, 24, 10, 5);
        chk_now("bad_hour", 0, 1, 1, 1'b0, 1'b1, 1'b0);
        idle_cycle();
        chk_now("err_one_cycle", 0, 1, 1, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b1, 12, 60, 0);
        chk_now("bad_min", 0, 1, 1, 1'b0, 1'b1, 1'b0);
        idle_cycle();

        // Day wrap
        apply(1'b0, 1'b0, 1'b0, 1'b1, 23, 59, 59);
        chk_now("load_235959", 23, 59, 59, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
        chk_now("day_wrap", 0, 0, 0, 1'b1, 1'b0, 1'b1);
        idle_cycle();
        chk_now("day_tick_one_cycle", 0, 0, 0, 1'b1, 1'b0, 1'b0);

        // Load refused in RUN, accepted once stopped
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1, 2, 3);
        chk_now("load_in_run", 0, 0, 0, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b1, 1, 2, 3);
        chk_now("stop_with_load", 0, 0, 0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1, 2, 3);
        chk_now("load_after_stop", 1, 2, 3, 1'b0, 1'b0, 1'b0);

        // Idle ticks discarded; stop + tick counted
        repeat (10) apply(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
        chk_now("idle_ticks", 1, 2, 3, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
        chk_now("run_tick", 1, 2, 4, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0);
        chk_now("stop_tick", 1, 2, 5, 1'b0, 1'b0, 1'b0);

        // Load with start, then count into the middle and reset
        apply(1'b1, 1'b0, 1'b0, 1'b1, 5, 30, 17);
        chk_now("load_and_start", 5, 30, 17, 1'b1, 1'b0, 1'b0);
        repeat (3) apply(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
        chk_now("pre_reset", 5, 30, 20, 1'b1, 1'b0, 1'b0);
        async_reset("async_reset");
        repeat (3) apply(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
        chk_now("idle_after_reset", 0, 0, 0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            st = ($urandom_range(0, 99) < 8);
            sp = ($urandom_range(0, 99) < 4);
            tk = ($urandom_range(0, 2) != 0);
            vl = ($urandom_range(0, 99) < 6);
            if ($urandom_range(0, 3) == 0) begin
                h = $urandom_range(0, 31);
                m = $urandom_range(0, 63);
                s = $urandom_range(0, 63);
            end else begin
                h = P - 1 - $urandom_range(0, 1);
                m = 59;
                s = $urandom_range(50, 59);
            end
            apply(st, sp, tk, vl, h, m, s);
            if (n == 1500) async_reset("async_reset_rand");
        end

        idle_cycle();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matbi_watch_time_cnt.md
MATBI_WATCH_TIME_CNT -- requirements
Module: matbi_watch_time_cnt

Interface
REQ-001 The block SHALL have parameter P_HOUR_MAX, default 24, giving the hour modulus (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port i_one_sec_tick, input, 1, a one-cycle pulse per elapsed second from the one-second generator.
REQ-005 The block SHALL have port i_start, input, 1, a pulse requesting IDLE->RUN.
REQ-006 The block SHALL have port i_stop, input, 1, a pulse requesting RUN->IDLE.
REQ-007 The block SHALL have port i_set_valid, input, 1, time-load request.
REQ-008 The block SHALL have ports i_set_hour (5), i_set_min (6) and i_set_sec (6), all inputs, carrying the load values.
REQ-009 The block SHALL have port o_set_ready, output, 1, high when a load can be accepted.
REQ-010 The block SHALL have port o_set_err, output, 1, a one-cycle pulse on a rejected load.
REQ-011 The block SHALL have ports o_hour (5), o_min (6) and o_sec (6), all registered outputs, carrying the current time.
REQ-012 The block SHALL have port o_running, output, 1, high while in state RUN.
REQ-013 The block SHALL have port o_day_tick, output, 1, a one-cycle pulse on the hour wrap.

Function
REQ-014 State machine SHALL have two states, IDLE (stopped, loadable) and RUN (counting).
REQ-015 In IDLE, i_start=1 and i_stop=0 SHALL transition to RUN; otherwise the state SHALL remain IDLE.
REQ-016 In RUN, i_stop=1 SHALL transition to IDLE (stop wins if i_start is also 1); i_start alone in RUN SHALL be ignored.
REQ-017 o_running SHALL equal (state==RUN) and be registered with the state.
REQ-018 Counting SHALL occur only in RUN on a cycle with i_one_sec_tick=1; ticks in IDLE SHALL be discarded, not queued.
REQ-019 A tick accepted at edge N SHALL make the updated time visible after edge N (latency 1 cycle).
REQ-020 A tick on the same cycle as the RUN->IDLE transition SHALL still be counted.
REQ-021 Second count: o_sec 0..59; o_sec==59 plus tick -> o_sec=0 and minute increment.
REQ-022 Minute count: o_min 0..59; o_min==59 with a minute increment -> o_min=0 and hour increment.
REQ-023 Hour count: o_hour 0..P_HOUR_MAX-1; an hour increment at P_HOUR_MAX-1 -> o_hour=0 and o_day_tick=1 for exactly one cycle.
REQ-024 All cascaded wraps SHALL complete in the same edge; no intermediate value (e.g. sec=0, min unchanged) SHALL ever be visible.
REQ-025 o_set_ready SHALL equal (state==IDLE).
REQ-026 A load is accepted when i_set_valid && o_set_ready; loads in RUN SHALL NOT be accepted, and upstream holds i_set_valid.
REQ-027 An accepted load SHALL be valid only if sec<60, min<60 and hour<P_HOUR_MAX; if valid, the time registers SHALL update after the same edge.
REQ-028 An accepted invalid load SHALL leave the time unchanged and pulse o_set_err for exactly one cycle.
REQ-029 A load and i_start in the same IDLE cycle SHALL apply the load and enter RUN; the first tick counts from the loaded value.
REQ-030 Outside the events above, o_day_tick and o_set_err SHALL be 0.

Reset
REQ-031 While reset=1 (asynchronously, including mid-count), state SHALL be IDLE and o_hour=0, o_min=0, o_sec=0, o_running=0, o_set_ready=1, o_set_err=0, o_day_tick=0.
REQ-032 After reset release, the block SHALL stay in IDLE until i_start; no pending tick or load SHALL survive reset.

Verification
REQ-033 Reset, then i_start, then 61 ticks -> o_hour=0, o_min=1, o_sec=1, o_running=1.
REQ-034 Load 23:59:59 in IDLE (P_HOUR_MAX=24), start, 1 tick -> next cycle 00:00:00 with o_day_tick=1 for one cycle only.
REQ-035 Load hour=24, min=10, sec=5 -> o_set_err=1 for one cycle, time unchanged; load 12:60:00 -> also rejected.
REQ-036 In RUN, assert i_set_valid with 01:02:03 -> o_set_ready=0, no update; then i_stop -> next cycle o_set_ready=1 and the load is accepted.
REQ-037 Ticks in IDLE (10 pulses) -> time unchanged; i_stop plus tick in the same cycle -> tick counted, state IDLE.
REQ-038 Assert reset asynchronously mid-count at 05:30:20 -> outputs zero immediately, without waiting for a clock edge; o_running=0.
